// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (CPU / external loader) arbiter in front of a
// single-port word RAM. Each access takes three cycles: IDLE (arbitrate and
// register the request), ACCESS (RAM strobe, grant pulse), RESP (load data
// returned). Byte/halfword stores are lane-replicated with a write mask and
// loads are aligned and sign/zero-extended.
// Build option: define MEM_ARB_ROUND_ROBIN_EN to alternate between
// simultaneous requesters; otherwise the CPU has fixed priority and the
// external port is protected by a starvation counter (STARVE_LIMIT).
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [2:0]        cpu_size,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic              cpu_err,
  output logic [31:0]       cpu_rdata,
  input  logic              ext_req,
  input  logic              ext_wr,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [2:0]        ext_size,
  input  logic [31:0]       ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic              ext_err,
  output logic [31:0]       ext_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_wmask,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_q;
  logic                win_ext_q;
  logic                load_q;
  logic [1:0]          off_q;
  logic [2:0]          size_q;
  logic                cpu_gnt_q, ext_gnt_q, cpu_err_q, ext_err_q;
  logic                cpu_rvalid_q, ext_rvalid_q;
  logic [31:0]         cpu_rdata_q, ext_rdata_q;
  logic                mem_en_q, mem_wr_q;
  logic [ADDR_W-3:0]   mem_addr_q;
  logic [3:0]          mem_wmask_q;
  logic [31:0]         mem_wdata_q;

  logic                ext_win;
  logic                sel_wr, sel_bad;
  logic [ADDR_W-1:0]   sel_addr;
  logic [2:0]          sel_size;
  logic [31:0]         sel_wdata, sel_rep;
  logic [3:0]          sel_lanes;
  logic [31:0]         ld_shift, ld_fmt;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic prio_ext_q;
  assign ext_win = ext_req & (~cpu_req | prio_ext_q);
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);
  logic [3:0] starve_q;
  assign ext_win = ext_req & (~cpu_req | (starve_q >= STARVE_LIM));
`endif

  // Winner's request fields, alignment check, lane mask and store replication
  always_comb begin
    sel_wr    = ext_win ? ext_wr    : cpu_wr;
    sel_addr  = ext_win ? ext_addr  : cpu_addr;
    sel_size  = ext_win ? ext_size  : cpu_size;
    sel_wdata = ext_win ? ext_wdata : cpu_wdata;
    sel_bad   = (sel_size == 3'b011) || (sel_size == 3'b110) || (sel_size == 3'b111) ||
                ((sel_size[1:0] == 2'b01) && sel_addr[0]) ||
                ((sel_size[1:0] == 2'b10) && (sel_addr[1:0] != 2'b00));
    sel_lanes = 4'b1111;
    sel_rep   = sel_wdata;
    case (sel_size[1:0])
      2'b00: begin
        sel_lanes = 4'b0001 << sel_addr[1:0];
        sel_rep   = {4{sel_wdata[7:0]}};
      end
      2'b01: begin
        sel_lanes = sel_addr[1] ? 4'b1100 : 4'b0011;
        sel_rep   = {2{sel_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Align returned RAM word and extend according to the registered size
  always_comb begin
    ld_shift = mem_rdata >> {off_q, 3'b000};
    case (size_q)
      3'b000:  ld_fmt = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_fmt = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_fmt = {24'h0, ld_shift[7:0]};
      3'b101:  ld_fmt = {16'h0, ld_shift[15:0]};
      default: ld_fmt = ld_shift;
    endcase
  end

  // Access FSM with registered strobes, arbitration state and rdata hold
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      win_ext_q    <= 1'b0;
      load_q       <= 1'b0;
      off_q        <= '0;
      size_q       <= '0;
      cpu_gnt_q    <= 1'b0;
      ext_gnt_q    <= 1'b0;
      cpu_err_q    <= 1'b0;
      ext_err_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      ext_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      ext_rdata_q  <= '0;
      mem_en_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wmask_q  <= '0;
      mem_wdata_q  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      prio_ext_q   <= 1'b0;
`else
      starve_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_req || ext_req) begin
            state_q     <= ACCESS;
            win_ext_q   <= ext_win;
            load_q      <= ~sel_bad & ~sel_wr;
            off_q       <= sel_addr[1:0];
            size_q      <= sel_size;
            cpu_gnt_q   <= ~ext_win;
            ext_gnt_q   <= ext_win;
            cpu_err_q   <= ~ext_win & sel_bad;
            ext_err_q   <= ext_win & sel_bad;
            mem_en_q    <= ~sel_bad;
            mem_wr_q    <= ~sel_bad & sel_wr;
            mem_addr_q  <= sel_bad ? '0 : sel_addr[ADDR_W-1:2];
            mem_wmask_q <= (~sel_bad & sel_wr) ? sel_lanes : 4'b0000;
            mem_wdata_q <= (~sel_bad & sel_wr) ? sel_rep : '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            prio_ext_q  <= ~ext_win;
`else
            if (ext_win)
              starve_q <= '0;
            else if (ext_req && (starve_q != 4'hF))
              starve_q <= starve_q + 4'd1;
`endif
          end
        end
        ACCESS: begin
          state_q      <= RESP;
          cpu_gnt_q    <= 1'b0;
          ext_gnt_q    <= 1'b0;
          cpu_err_q    <= 1'b0;
          ext_err_q    <= 1'b0;
          mem_en_q     <= 1'b0;
          mem_wr_q     <= 1'b0;
          mem_addr_q   <= '0;
          mem_wmask_q  <= '0;
          mem_wdata_q  <= '0;
          cpu_rvalid_q <= load_q & ~win_ext_q;
          ext_rvalid_q <= load_q & win_ext_q;
        end
        RESP: begin
          state_q      <= IDLE;
          cpu_rvalid_q <= 1'b0;
          ext_rvalid_q <= 1'b0;
          if (cpu_rvalid_q) cpu_rdata_q <= ld_fmt;
          if (ext_rvalid_q) ext_rdata_q <= ld_fmt;
        end
        default: state_q <= IDLE;
      endcase
`ifndef MEM_ARB_ROUND_ROBIN_EN
      // A withdrawn ext request forgets any accumulated starvation
      if (!ext_req) starve_q <= '0;
`endif
    end
  end

  // Strobes are masked while rst is low so a reset landing in RESP
  // suppresses the pending rvalid in that same cycle.
  assign cpu_gnt    = cpu_gnt_q    & rst;
  assign ext_gnt    = ext_gnt_q    & rst;
  assign cpu_err    = cpu_err_q    & rst;
  assign ext_err    = ext_err_q    & rst;
  assign cpu_rvalid = cpu_rvalid_q & rst;
  assign ext_rvalid = ext_rvalid_q & rst;
  assign mem_en     = mem_en_q     & rst;
  assign mem_wr     = mem_wr_q     & rst;
  assign mem_wmask  = mem_wmask_q  & {4{rst}};
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_rdata  = cpu_rvalid_q ? ld_fmt : cpu_rdata_q;
  assign ext_rdata  = ext_rvalid_q ? ld_fmt : ext_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a small behavioural
// RAM (one-cycle read latency, byte-masked writes). Honours
// MEM_ARB_ROUND_ROBIN_EN for the expected grant order.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_wr, ext_req, ext_wr;
  logic [31:0] cpu_addr, ext_addr, cpu_wdata, ext_wdata;
  logic [2:0]  cpu_size, ext_size;
  logic        cpu_gnt, cpu_rvalid, cpu_err, ext_gnt, ext_rvalid, ext_err;
  logic [31:0] cpu_rdata, ext_rdata;
  logic        mem_en, mem_wr;
  logic [29:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] ram [0:15];

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_size(cpu_size),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_wr(ext_wr), .ext_addr(ext_addr), .ext_size(ext_size),
    .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid),
    .ext_err(ext_err), .ext_rdata(ext_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Behavioural single-port RAM
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr)
        for (int i = 0; i < 4; i++)
          if (mem_wmask[i]) ram[mem_addr[3:0]][8*i +: 8] <= mem_wdata[8*i +: 8];
      mem_rdata <= ram[mem_addr[3:0]];
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request in IDLE and advance into the ACCESS cycle
  task automatic cpu_go(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd);
    cpu_req = 1'b1; cpu_wr = wr; cpu_addr = a; cpu_size = sz; cpu_wdata = wd;
    tick();
    cpu_req = 1'b0;
  endtask

  task automatic ext_go(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd);
    ext_req = 1'b1; ext_wr = wr; ext_addr = a; ext_size = sz; ext_wdata = wd;
    tick();
    ext_req = 1'b0;
  endtask

  initial begin
    logic [47:0] order;
    logic [47:0] exp_order;
    int n;
    rst = 1'b0;
    cpu_req = 0; cpu_wr = 0; cpu_addr = 0; cpu_size = 0; cpu_wdata = 0;
    ext_req = 0; ext_wr = 0; ext_addr = 0; ext_size = 0; ext_wdata = 0;
    tick(); tick();
    chk("rst_cpu_gnt", cpu_gnt, 0);
    chk("rst_ext_gnt", ext_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_wmask", mem_wmask, 0);
    chk("rst_rvalid", {cpu_rvalid, ext_rvalid, cpu_err, ext_err}, 0);
    rst = 1'b1;
    tick();

    // SW 0x10
    cpu_go(1, 32'h10, 3'b010, 32'h8899AABB);
    chk("sw_gnt", {cpu_gnt, ext_gnt, mem_en, mem_wr}, 4'b1011);
    chk("sw_mask", mem_wmask, 4'b1111);
    chk("sw_addr", mem_addr, 4);
    chk("sw_wdata", mem_wdata, 32'h8899AABB);
    tick();
    chk("sw_no_rvalid", cpu_rvalid, 0);
    tick();

    // LW 0x10: gnt in cycle 2, rvalid in cycle 3
    cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h10; cpu_size = 3'b010;
    chk("lw_c1_gnt", cpu_gnt, 0);
    tick(); cpu_req = 0;
    chk("lw_c2_gnt", {cpu_gnt, mem_en, mem_wr, mem_wmask}, 7'b1100000);
    tick();
    chk("lw_c3_rvalid", cpu_rvalid, 1);
    chk("lw_rdata", cpu_rdata, 32'h8899AABB);
    tick();
    chk("lw_rvalid_end", cpu_rvalid, 0);
    chk("lw_rdata_hold", cpu_rdata, 32'h8899AABB);

    // Sub-word loads from 0x80112233
    cpu_go(1, 32'h10, 3'b010, 32'h80112233); tick(); tick();
    cpu_go(0, 32'h13, 3'b000, 0); tick();
    chk("lb_rdata", {cpu_rvalid, cpu_rdata}, {1'b1, 32'hFFFFFF80}); tick();
    cpu_go(0, 32'h13, 3'b100, 0); tick();
    chk("lbu_rdata", {cpu_rvalid, cpu_rdata}, {1'b1, 32'h00000080}); tick();
    cpu_go(0, 32'h12, 3'b001, 0); tick();
    chk("lh_rdata", {cpu_rvalid, cpu_rdata}, {1'b1, 32'hFFFF8011}); tick();
    cpu_go(0, 32'h12, 3'b101, 0); tick();
    chk("lhu_rdata", {cpu_rvalid, cpu_rdata}, {1'b1, 32'h00008011}); tick();

    // SH 0x06 and SB 0x05
    cpu_go(1, 32'h06, 3'b001, 32'h0000BEEF);
    chk("sh_mask", mem_wmask, 4'b1100);
    chk("sh_wdata", mem_wdata, 32'hBEEFBEEF);
    chk("sh_addr", {mem_en, mem_wr, mem_addr}, {2'b11, 30'd1});
    tick();
    chk("sh_no_rvalid", cpu_rvalid, 0);
    tick();
    cpu_go(1, 32'h05, 3'b000, 32'h000000A5);
    chk("sb_mask", mem_wmask, 4'b0010);
    chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
    tick(); tick();

    // Misaligned LW and illegal size
    cpu_go(0, 32'h02, 3'b010, 0);
    chk("mis_acc", {cpu_gnt, cpu_err, mem_en, mem_wr}, 4'b1100);
    tick();
    chk("mis_resp", {cpu_rvalid, cpu_err, cpu_gnt}, 3'b000);
    tick();
    cpu_go(0, 32'h10, 3'b011, 0);
    chk("ill_acc", {cpu_gnt, cpu_err, mem_en}, 3'b110);
    tick();
    chk("ill_resp", cpu_rvalid, 0);
    tick();

    // External load
    ext_go(0, 32'h10, 3'b010, 0);
    chk("ext_acc", {ext_gnt, cpu_gnt, ext_err, mem_en}, 4'b1001);
    tick();
    chk("ext_resp", {ext_rvalid, cpu_rvalid, ext_rdata}, {2'b10, 32'h80112233});
    tick();

    // Both requesters held high
    cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h10; cpu_size = 3'b010;
    ext_req = 1; ext_wr = 0; ext_addr = 32'h10; ext_size = 3'b010;
    order = '0;
    n = 0;
    for (int c = 0; c < 60 && n < 6; c++) begin
      tick();
      if (cpu_gnt && ext_gnt)  begin order = {order[39:0], 8'h58}; n++; end
      else if (cpu_gnt)        begin order = {order[39:0], 8'h43}; n++; end
      else if (ext_gnt)        begin order = {order[39:0], 8'h45}; n++; end
    end
    cpu_req = 0; ext_req = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_order = 48'h434543454345;   // "CECECE"
`else
    exp_order = 48'h434343434543;   // "CCCCEC"
`endif
    chk("arb_count", n, 6);
    chk("arb_order", order, exp_order);
    tick(); tick();

    // Reset during RESP of an external load
    ext_go(0, 32'h10, 3'b010, 0);
    tick();
    rst = 1'b0; #1;
    chk("rst_resp_rvalid", ext_rvalid, 0);
    tick();
    rst = 1'b1; #1;
    chk("post_rst_idle", {ext_rvalid, ext_gnt, cpu_gnt, mem_en}, 0);
    tick();
    chk("post_rst_no_rvalid", ext_rvalid, 0);
    cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h10; cpu_size = 3'b010;
    ext_req = 1; ext_wr = 0; ext_addr = 32'h10; ext_size = 3'b010;
    tick();
    cpu_req = 0; ext_req = 0;
    chk("post_rst_prio", {cpu_gnt, ext_gnt}, 2'b10);
    tick();
    chk("post_rst_load", {cpu_rvalid, ext_rvalid, cpu_rdata}, {2'b10, 32'h80112233});
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, 4, consecutive CPU grants while ext_req is pending before ext is forced to win (range 1..15).
REQ-002 Parameter: ADDR_W, 32, address width of all ports.
REQ-003 clk  in  1  clock; all logic on posedge clk.
REQ-004 rst  in  1  reset rst, synchronous, active-low; clock clk.
REQ-005 cpu_req  in  1  CPU access request; held until cpu_gnt.
REQ-006 cpu_wr  in  1  1=store, 0=load.
REQ-007 cpu_addr  in  ADDR_W  byte address.
REQ-008 cpu_size  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 cpu_wdata  in  32  store data, right-aligned.
REQ-010 cpu_gnt / cpu_rvalid / cpu_err  out  1 each  grant pulse / load-data-valid pulse / misaligned-access pulse.
REQ-011 cpu_rdata  out  32  aligned, sign/zero-extended load data.
REQ-012 ext_req, ext_wr, ext_addr, ext_size, ext_wdata  in  same widths as cpu_*  second requester (UART loader/debug).
REQ-013 ext_gnt, ext_rvalid, ext_err, ext_rdata  out  same as cpu_*.
REQ-014 mem_en  out  1, mem_wr  out  1, mem_addr  out  ADDR_W-2 (word address), mem_wmask  out  4, mem_wdata  out  32, mem_rdata  in  32  single-port RAM; read data valid the cycle after mem_en.

Function
REQ-015 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS when any req; ACCESS->RESP always; RESP->IDLE always.
REQ-016 In IDLE the winner's wr/addr/size/wdata are registered; requests not present in IDLE are not sampled.
REQ-017 In ACCESS: mem_en=1 for exactly one cycle, winner's gnt=1 for exactly that cycle, loser's gnt=0.
REQ-018 In RESP: for a load, winner's rvalid=1 one cycle with rdata valid; for a store, rvalid stays 0.
REQ-019 One access per 3 cycles max; back-to-back request returns to ACCESS no earlier than 3 cycles after previous ACCESS.
REQ-020 mem_addr = addr[ADDR_W-1:2]; mem_wmask: B -> 1 lane at addr[1:0]; H -> lanes {addr[1],1:0} pair; W -> 4'b1111; loads drive mem_wmask=0.
REQ-021 mem_wdata replicates cpu/ext wdata: B as 4 copies of byte, H as 2 copies of halfword, W unchanged.
REQ-022 Load data shifted right by addr[1:0] bytes; B/H sign-extended, BU/HU zero-extended, W unchanged.
REQ-023 Misaligned (H/HU with addr[0]=1, W with addr[1:0]!=0) or size 011/110/111: no mem_en, no mem write, gnt and err pulse together in ACCESS, no rvalid.
REQ-024 Starvation counter increments on each CPU grant while ext_req=1, clears on ext grant or ext_req=0; at STARVE_LIMIT ext wins next arbitration.
REQ-025 Outputs not owned by the active access are 0; rdata holds last value between rvalid pulses.

Reset
REQ-026 rst=0 at any cycle: state IDLE, mem_en/mem_wr/mem_wmask=0, all gnt/rvalid/err=0, starvation counter=0, priority pointer=CPU.
REQ-027 Reset in ACCESS or RESP aborts the access; no rvalid is issued afterwards for it.

Configuration
REQ-028 Macro MEM_ARB_ROUND_ROBIN_EN defined: simultaneous requests alternate, winner is the port not granted last; starvation counter absent.
REQ-029 Macro MEM_ARB_ROUND_ROBIN_EN undefined: CPU has fixed priority, ext protected by STARVE_LIMIT counter (REQ-024).

Verification
REQ-030 CPU LW addr 0x10, mem word 0x8899AABB -> gnt in cycle 2, cpu_rvalid cycle 3, cpu_rdata 0x8899AABB.
REQ-031 CPU LB addr 0x13 then LBU addr 0x13, word 0x80112233 -> rdata 0xFFFFFF80 then 0x00000080.
REQ-032 CPU SH addr 0x06 data 0x0000BEEF -> mem_wmask 4'b1100, mem_wdata 0xBEEFBEEF, mem_addr 1, no rvalid.
REQ-033 CPU LW addr 0x02 -> cpu_err and cpu_gnt pulse, mem_en stays 0, no rvalid.
REQ-034 cpu_req and ext_req held high, STARVE_LIMIT=4, macro undefined -> grant order C,C,C,C,E,C...; macro defined -> C,E,C,E.
REQ-035 rst=0 during RESP of an ext load -> ext_rvalid never asserted, next access starts from IDLE with CPU priority.
